// File: rtl/jt6295_pkg.sv
// Shared constants and sizing helpers for the JT6295 N-slot accumulator.
package jt6295_pkg;

    localparam int unsigned VOL_UNITY = 16;
    localparam int unsigned VOL_W     = 5;

    // Bits needed to count 0..ch slot strobes
    function automatic int unsigned slot_w(input int unsigned ch);
        return $clog2(ch + 1);
    endfunction

    // Accumulator width that cannot wrap for ch full-scale terms
    function automatic int unsigned acc_w(input int unsigned iw, input int unsigned ch);
        return iw + 2 + $clog2(ch) + 1;
    endfunction

endpackage

// File: rtl/jt6295_accn_if.sv
// Slot/frame bus between the ADPCM decoder pipeline and the mixer.
interface jt6295_accn_if
    import jt6295_pkg::*;
#(
    parameter int unsigned IW = 12,
    parameter int unsigned OW = 14
);

    logic                    cen;
    logic                    cen_ch;
    logic signed [IW-1:0]    snd_in;
    logic                    snd_en;
    logic [VOL_W-1:0]        vol;
    logic                    clr_flags;
    logic signed [OW-1:0]    sound;
    logic                    sample_ok;
    logic                    clip;
    logic                    ovr;

    modport master (
        output cen, cen_ch, snd_in, snd_en, vol, clr_flags,
        input  sound, sample_ok, clip, ovr
    );

    modport slave (
        input  cen, cen_ch, snd_in, snd_en, vol, clr_flags,
        output sound, sample_ok, clip, ovr
    );

endinterface

// File: rtl/jt6295_accn_term.sv
// Per-slot volume scaling: (snd * vol) >>> 4, zero when the slot is muted.
module jt6295_accn_term
    import jt6295_pkg::*;
#(
    parameter int unsigned IW = 12
) (
    input  logic signed [IW-1:0]   snd_i,
    input  logic [VOL_W-1:0]       vol_i,
    input  logic                   en_i,
    output logic signed [IW+1:0]   term_c_o
);

    localparam int unsigned PW     = IW + VOL_W + 1;
    localparam int unsigned VOL_SH = $clog2(VOL_UNITY);

    logic signed [PW-1:0] prod_c;

    // Signed multiply kept alone for DSP inference; arithmetic shift floors
    always_comb begin
        prod_c   = PW'(snd_i) * PW'($signed({1'b0, vol_i}));
        term_c_o = en_i ? (IW+2)'(prod_c >>> VOL_SH) : '0;
    end

endmodule

// File: rtl/jt6295_accn.sv
// N-slot ADPCM mixer: sums scaled slot terms per frame, saturates, flags clip/overrun.
module jt6295_accn
    import jt6295_pkg::*;
#(
    parameter int unsigned CH     = 4,
    parameter int unsigned IW     = 12,
    parameter int unsigned OW     = 14,
    parameter int unsigned OUT_SH = 0
) (
    input  logic          clk,
    input  logic          rst,
    jt6295_accn_if.slave  bus
);

    localparam int unsigned ACCW   = acc_w(IW, CH);
    localparam int unsigned SLOT_W = slot_w(CH);
    localparam int unsigned SHW    = ACCW + OUT_SH;
    localparam int unsigned SW     = ((SHW > OW) ? SHW : OW) + 1;

    logic signed [IW+1:0]   term_c;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [SLOT_W-1:0]      cnt_q, cnt_d;
    logic signed [OW-1:0]   sound_q, sound_d;
    logic                   sample_ok_q, sample_ok_d;
    logic                   clip_q, clip_d;
    logic                   ovr_q, ovr_d;
    logic signed [SW-1:0]   frame_s, sat_max, sat_min;
    logic                   sat_hi, sat_lo;

    jt6295_accn_term #(
        .IW (IW)
    ) u_term (
        .snd_i    (bus.snd_in),
        .vol_i    (bus.vol),
        .en_i     (bus.snd_en),
        .term_c_o (term_c)
    );

    // Frame sum moved to output scale and compared against the output range
    always_comb begin
        frame_s = SW'(acc_q) <<< OUT_SH;
        sat_max = '0;
        sat_max[OW-2:0] = '1;
        sat_min = '1;
        sat_min[OW-2:0] = '0;
        sat_hi  = frame_s > sat_max;
        sat_lo  = frame_s < sat_min;
    end

    // Frame close has priority; a coincident slot strobe opens the next frame
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sound_d     = sound_q;
        sample_ok_d = 1'b0;
        clip_d      = bus.clr_flags ? 1'b0 : clip_q;
        ovr_d       = bus.clr_flags ? 1'b0 : ovr_q;

        if (bus.cen) begin
            sample_ok_d = 1'b1;
            if (sat_hi) begin
                sound_d = sat_max[OW-1:0];
                clip_d  = 1'b1;
            end else if (sat_lo) begin
                sound_d = sat_min[OW-1:0];
                clip_d  = 1'b1;
            end else begin
                sound_d = frame_s[OW-1:0];
            end
            if (bus.cen_ch) begin
                acc_d = ACCW'(term_c);
                cnt_d = SLOT_W'(1);
            end else begin
                acc_d = '0;
                cnt_d = '0;
            end
        end else if (bus.cen_ch) begin
            if (cnt_q < SLOT_W'(CH)) begin
                acc_d = acc_q + ACCW'(term_c);
                cnt_d = cnt_q + SLOT_W'(1);
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            sound_q     <= '0;
            sample_ok_q <= 1'b0;
            clip_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sound_q     <= sound_d;
            sample_ok_q <= sample_ok_d;
            clip_q      <= clip_d;
            ovr_q       <= ovr_d;
        end
    end

    assign bus.sound     = sound_q;
    assign bus.sample_ok = sample_ok_q;
    assign bus.clip      = clip_q;
    assign bus.ovr       = ovr_q;

endmodule

// File: tb/tb_jt6295_accn.sv
// Scoreboard bench for jt6295_accn: directed frames followed by random frames.
`timescale 1ns/1ps
module tb_jt6295_accn;
    import jt6295_pkg::*;

    localparam int unsigned CH     = 4;
    localparam int unsigned IW     = 12;
    localparam int unsigned OW     = 14;
    localparam int unsigned OUT_SH = 0;
    localparam int OUT_MAX = (1 <<< (OW - 1)) - 1;
    localparam int OUT_MIN = -(1 <<< (OW - 1));

    typedef struct {
        int sound;
        int clip;
        int ovr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jt6295_accn_if #(.IW(IW), .OW(OW)) bus ();

    jt6295_accn #(
        .CH     (CH),
        .IW     (IW),
        .OW     (OW),
        .OUT_SH (OUT_SH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: running frame sum, strobes seen, sticky flags
    int   m_sum  = 0;
    int   m_cnt  = 0;
    int   m_clip = 0;
    int   m_ovr  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // floor(snd * vol / 16) by plain integer arithmetic
    function automatic int ref_term(input int s, input int v, input int en);
        int p;
        if (en == 0) return 0;
        p = s * v;
        if (p >= 0) return p / int'(VOL_UNITY);
        return -((-p + int'(VOL_UNITY) - 1) / int'(VOL_UNITY));
    endfunction

    function automatic int clamp_out(input int x);
        if (x > OUT_MAX) return OUT_MAX;
        if (x < OUT_MIN) return OUT_MIN;
        return x;
    endfunction

    task automatic drive_slot(input int s, input int en, input int v);
        bus.snd_in = IW'(s);
        bus.snd_en = en[0];
        bus.vol    = VOL_W'(v);
    endtask

    task automatic slot(input int s, input int en, input int v);
        if (m_cnt < int'(CH)) begin
            m_sum += ref_term(s, v, en);
            m_cnt++;
        end else begin
            m_ovr = 1;
        end
        drive_slot(s, en, v);
        bus.cen_ch = 1'b1;
        @(posedge clk); #1;
        bus.cen_ch = 1'b0;
    endtask

    task automatic close(input int with_slot, input int s, input int en, input int v);
        exp_t e;
        int   scaled;
        scaled = m_sum * (1 <<< OUT_SH);
        if (clamp_out(scaled) != scaled) m_clip = 1;
        e.sound = clamp_out(scaled);
        e.clip  = m_clip;
        e.ovr   = m_ovr;
        exp_q.push_back(e);
        if (with_slot != 0) begin
            m_sum = ref_term(s, v, en);
            m_cnt = 1;
            drive_slot(s, en, v);
        end else begin
            m_sum = 0;
            m_cnt = 0;
        end
        bus.cen    = 1'b1;
        bus.cen_ch = (with_slot != 0);
        @(posedge clk); #1;
        bus.cen    = 1'b0;
        bus.cen_ch = 1'b0;
        check("sample_ok_latency", int'(bus.sample_ok), 1);
    endtask

    task automatic clr();
        bus.clr_flags = 1'b1;
        @(posedge clk); #1;
        bus.clr_flags = 1'b0;
        m_clip = 0;
        m_ovr  = 0;
        check("clip_after_clr", int'(bus.clip), 0);
        check("ovr_after_clr", int'(bus.ovr), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        m_sum  = 0;
        m_cnt  = 0;
        m_clip = 0;
        m_ovr  = 0;
        check("reset_sound", int'(bus.sound), 0);
        check("reset_sample_ok", int'(bus.sample_ok), 0);
        check("reset_clip", int'(bus.clip), 0);
        check("reset_ovr", int'(bus.ovr), 0);
    endtask

    // Monitor: compare every presented sample against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.sample_ok) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sample_ok", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sound", int'(bus.sound), e.sound);
                    check("clip", int'(bus.clip), e.clip);
                    check("ovr", int'(bus.ovr), e.ovr);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int n;
        bus.cen       = 1'b0;
        bus.cen_ch    = 1'b0;
        bus.snd_in    = '0;
        bus.snd_en    = 1'b0;
        bus.vol       = '0;
        bus.clr_flags = 1'b0;
        #12;
        do_reset();

        // Unity mix
        repeat (4) slot(2047, 1, 16);
        close(0, 0, 0, 0);

        // Positive saturation, sticky clip, then clear
        repeat (4) slot(2047, 1, 31);
        close(0, 0, 0, 0);
        repeat (4) slot(100, 1, 16);
        close(0, 0, 0, 0);
        clr();

        // Negative saturation and floor rounding
        repeat (4) slot(-2048, 1, 31);
        close(0, 0, 0, 0);
        slot(-1, 1, 8);
        close(0, 0, 0, 0);
        clr();

        // Short frame with a muted slot
        slot(100, 1, 16);
        slot(500, 0, 16);
        close(0, 0, 0, 0);

        // Overrun, then next frame restarts at slot 0
        repeat (5) slot(10, 1, 16);
        close(0, 0, 0, 0);
        repeat (4) slot(7, 1, 16);
        close(0, 0, 0, 0);
        clr();

        // Coincident frame close and slot strobe
        repeat (3) slot(100, 1, 16);
        close(1, 50, 1, 16);
        close(0, 0, 0, 0);

        // Reset mid-frame discards the partial sum
        slot(1000, 1, 16);
        slot(1000, 1, 16);
        do_reset();
        slot(25, 1, 16);
        close(0, 0, 0, 0);

        // Random frames
        for (int f = 0; f < 300; f++) begin
            n = int'($urandom_range(0, 6));
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                slot(int'($urandom_range(0, 4095)) - 2048,
                     int'($urandom_range(0, 4) != 0),
                     int'($urandom_range(0, 31)));
            end
            if ($urandom_range(0, 7) == 0)
                close(1, int'($urandom_range(0, 4095)) - 2048, 1, int'($urandom_range(0, 31)));
            else
                close(0, 0, 0, 0);
            if ($urandom_range(0, 9) == 0) clr();
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
